// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the pipeline FIFO.
// Default geometry is reused by the testbenches.
package fifo_pkg;

  localparam int FWFT_ON  = 1;
  localparam int FWFT_OFF = 0;

  localparam int DEF_SIZE = 5;
  localparam int DEF_DATA = 32;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag control for fifo_pipeline_ff.
// Flags are registered from the next-state count.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int SIZE      = DEF_SIZE,
  parameter  int AF_THRESH = 4,
  parameter  int AE_THRESH = 1,
  localparam int CW        = clog2(SIZE + 1),
  localparam int PW        = (clog2(SIZE) < 1) ? 1 : clog2(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          shift_in,
  input  logic          shift_out,
  output logic          push_ok,
  output logic          pop_ok,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] rd_nxt,
  output logic          head_vld_nxt,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);
  localparam logic [CW-1:0] SZ   = CW'(SIZE);
  localparam logic [CW-1:0] AF   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE   = CW'(AE_THRESH);

  logic [PW-1:0] wr_nxt;
  logic [CW-1:0] count_nxt;
  logic          ovf_nxt;
  logic          udf_nxt;

  // Explicit wrap: depth need not be a power of two.
  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Accept decisions and next-state pointers, count and errors.
  always_comb begin
    push_ok = !clear && shift_in
            && (!full || shift_out);
    pop_ok  = !clear && shift_out && !empty;
    wr_nxt  = push_ok ? bump(wr_ptr) : wr_ptr;
    rd_nxt  = pop_ok  ? bump(rd_ptr) : rd_ptr;
    if (clear) begin
      wr_nxt = '0;
      rd_nxt = '0;
    end
    unique case (1'b1)
      clear:
        count_nxt = '0;
      push_ok && !pop_ok:
        count_nxt = count + CW'(1);
      pop_ok && !push_ok:
        count_nxt = count - CW'(1);
      default:
        count_nxt = count;
    endcase
    head_vld_nxt = !clear && (count_nxt != '0);
    ovf_nxt = !clear && (overflow
            || (shift_in && !push_ok));
    udf_nxt = !clear && (underflow
            || (shift_out && !pop_ok));
  end

  // Register pointers, count and all status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_nxt;
      rd_ptr       <= rd_nxt;
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == SZ);
      almost_empty <= (count_nxt <= AE);
      almost_full  <= (count_nxt >= AF);
      overflow     <= ovf_nxt;
      underflow    <= udf_nxt;
    end
  end

endmodule

// File: rtl/fifo_pipeline_ff.sv
// Elastic pipeline FIFO: any depth, FWFT or registered read,
// programmable almost flags, sticky errors, synchronous flush.
module fifo_pipeline_ff
  import fifo_pkg::*;
#(
  parameter  int SIZE      = DEF_SIZE,
  parameter  int DATA      = DEF_DATA,
  parameter  int FWFT      = FWFT_ON,
  parameter  int AF_THRESH = 4,
  parameter  int AE_THRESH = 1,
  localparam int CW        = clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [DATA-1:0] data_in,
  input  logic            shift_in,
  input  logic            shift_out,
  output logic [DATA-1:0] data_out,
  output logic            empty,
  output logic            full,
  output logic            almost_empty,
  output logic            almost_full,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic            underflow
);

  localparam int PW = (clog2(SIZE) < 1) ? 1 : clog2(SIZE);

  logic [DATA-1:0] mem [SIZE];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_nxt;
  logic            push_ok;
  logic            pop_ok;
  logic            head_vld_nxt;
  logic            load;
  logic [DATA-1:0] dnxt;

  fifo_ptr_ctrl #(
    .SIZE      (SIZE),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .shift_in     (shift_in),
    .shift_out    (shift_out),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .rd_nxt       (rd_nxt),
    .head_vld_nxt (head_vld_nxt),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  // FWFT shows the post-edge head, bypassing a word
  // written into the head slot; otherwise load on pop.
  always_comb begin
    if (FWFT == FWFT_ON) begin
      load = head_vld_nxt;
      dnxt = (push_ok && wr_ptr == rd_nxt)
           ? data_in : mem[rd_nxt];
    end else begin
      load = pop_ok;
      dnxt = mem[rd_ptr];
    end
  end

  // Output register; holds while nothing new is shown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_out <= '0;
    else if (load) data_out <= dnxt;
  end

endmodule
